// File: rtl/ctrl_int.sv
// ctrl_int: 4-line interrupt controller driving the datapath ie1..ie4 inputs.
// Synchronises irq, latches rising edges as pending, fires one ie pulse per
// request by fixed priority (irq[0] highest) and tracks lines in service.
// Ports: clk; reset (async, active low); irq[3:0] raw requests; gie global
//   enable; mask[3:0] per-line enable; reti return-from-interrupt pulse;
//   ie1..ie4 one-hot fire pulses; pending[3:0]; in_service[3:0].
// Build option: define INT_NEST_EN to let a strictly higher-priority request
//   preempt the lines currently in service (nested interrupts).
module ctrl_int #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq,
    input  logic       gie,
    input  logic [3:0] mask,
    input  logic       reti,
    output logic       ie1,
    output logic       ie2,
    output logic       ie3,
    output logic       ie4,
    output logic [3:0] pending,
    output logic [3:0] in_service
);

`ifdef INT_NEST_EN
    localparam bit NestEn = 1'b1;
`else
    localparam bit NestEn = 1'b0;
`endif

    // Edges are trusted only once the sync chain and the edge register
    // both hold real samples, so a line already high at reset release
    // is not mistaken for a request.
    localparam logic [2:0] ArmN = 3'(SYNC_STAGES + 1);
    localparam logic [3:0] Gap  = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] prev_q;
    logic [2:0] arm_q, arm_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] in_service_q, in_service_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] ie_q, ie_d;

    logic [3:0] sync_out;
    logic [3:0] rise;
    logic [3:0] elig;
    logic [3:0] win;
    logic [3:0] is_hi;
    logic [3:0] pend_clr;
    logic [3:0] is_set;
    logic [3:0] is_clr;
    logic       gap_load;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = (arm_q == ArmN) ? (sync_out & ~prev_q) : 4'b0000;
    assign elig     = pending_q & mask & {4{gie}};
    // Lowest set bit = highest priority.
    assign win      = elig & (~elig + 4'd1);
    assign is_hi    = in_service_q & (~in_service_q + 4'd1);

    always_comb begin
        state_d  = state_q;
        ie_d     = 4'b0000;
        pend_clr = 4'b0000;
        is_set   = 4'b0000;
        is_clr   = 4'b0000;
        gap_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (elig != 4'b0000 && gap_q == 4'd0) begin
                    state_d = FIRE;
                    ie_d    = win;
                end
            end
            FIRE: begin
                // ie_q still holds the line chosen on entry.
                pend_clr = ie_q;
                is_set   = ie_q;
                state_d  = SERVICE;
            end
            SERVICE: begin
                if (reti && in_service_q != 4'b0000) begin
                    is_clr   = is_hi;
                    gap_load = 1'b1;
                    if ((in_service_q & ~is_hi) == 4'b0000) begin
                        state_d = IDLE;
                    end
                end else if (NestEn && gap_q == 4'd0 &&
                             (elig & (is_hi - 4'd1)) != 4'b0000) begin
                    // is_hi - 1 masks the lines above the current one.
                    state_d = FIRE;
                    ie_d    = win;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A rise in the same cycle as the clear wins, so it is not lost.
    assign pending_d    = (pending_q & ~pend_clr) | rise;
    assign in_service_d = (in_service_q & ~is_clr) | is_set;
    assign arm_d        = (arm_q == ArmN) ? arm_q : arm_q + 3'd1;

    always_comb begin
        gap_d = gap_q;
        if (gap_load) begin
            gap_d = Gap;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            prev_q       <= 4'b0000;
            arm_q        <= 3'd0;
            pending_q    <= 4'b0000;
            in_service_q <= 4'b0000;
            gap_q        <= 4'd0;
            ie_q         <= 4'b0000;
            state_q      <= IDLE;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], irq};
            prev_q       <= sync_out;
            arm_q        <= arm_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            gap_q        <= gap_d;
            ie_q         <= ie_d;
            state_q      <= state_d;
        end
    end

    assign ie1        = ie_q[0];
    assign ie2        = ie_q[1];
    assign ie3        = ie_q[2];
    assign ie4        = ie_q[3];
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_ctrl_int.sv
// tb_ctrl_int: directed vector table plus hand sequences for ctrl_int.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ctrl_int;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       gie;
    logic [3:0] mask;
    logic       reti;
    logic       ie1, ie2, ie3, ie4;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [3:0] ie;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ie = {ie4, ie3, ie2, ie1};

    ctrl_int dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .gie        (gie),
        .mask       (mask),
        .reti       (reti),
        .ie1        (ie1),
        .ie2        (ie2),
        .ie3        (ie3),
        .ie4        (ie4),
        .pending    (pending),
        .in_service (in_service)
    );

    typedef struct {
        logic [3:0] irq;
        logic       gie;
        logic [3:0] mask;
        logic       reti;
        logic [3:0] ie;
        logic [3:0] pend;
        logic [3:0] isv;
    } vec_t;

    vec_t tbl[37];

    function automatic vec_t v(logic [3:0] i, logic g, logic [3:0] m,
                               logic r, logic [3:0] e, logic [3:0] p,
                               logic [3:0] s);
        vec_t t;
        t.irq = i; t.gie = g; t.mask = m; t.reti = r;
        t.ie = e; t.pend = p; t.isv = s;
        return t;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ie(string name, logic [3:0] exp, int max);
        int n = 0;
        while (ie == 4'b0000 && n < max) begin
            cyc();
            n++;
        end
        chk(name, ie, exp);
    endtask

    task automatic drv(logic [3:0] i, logic r);
        irq  = i;
        reti = r;
    endtask

    initial begin
        // Table: T2, T3, T4, gie gating, reti with nothing in service.
        tbl[0]  = v(4'b0100, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[1]  = v(4'b0100, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[2]  = v(4'b0100, 1, 4'hF, 0, 4'b0000, 4'b0100, 4'b0000);
        tbl[3]  = v(4'b0100, 1, 4'hF, 0, 4'b0100, 4'b0100, 4'b0000);
        tbl[4]  = v(4'b0100, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0100);
        tbl[5]  = v(4'b0100, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0100);
        tbl[6]  = v(4'b0100, 1, 4'hF, 1, 4'b0000, 4'b0000, 4'b0000);
        tbl[7]  = v(4'b0100, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[8]  = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[9]  = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[10] = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b1010, 4'b0000);
        tbl[11] = v(4'b1010, 1, 4'hF, 0, 4'b0010, 4'b1010, 4'b0000);
        tbl[12] = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b1000, 4'b0010);
        tbl[13] = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b1000, 4'b0010);
        tbl[14] = v(4'b1010, 1, 4'hF, 1, 4'b0000, 4'b1000, 4'b0000);
        tbl[15] = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b1000, 4'b0000);
        tbl[16] = v(4'b1010, 1, 4'hF, 0, 4'b1000, 4'b1000, 4'b0000);
        tbl[17] = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b1000);
        tbl[18] = v(4'b1010, 1, 4'hF, 1, 4'b0000, 4'b0000, 4'b0000);
        tbl[19] = v(4'b1010, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[20] = v(4'b1011, 1, 4'hE, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[21] = v(4'b1011, 1, 4'hE, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[22] = v(4'b1011, 1, 4'hE, 0, 4'b0000, 4'b0001, 4'b0000);
        tbl[23] = v(4'b1011, 1, 4'hE, 0, 4'b0000, 4'b0001, 4'b0000);
        tbl[24] = v(4'b1011, 1, 4'hF, 0, 4'b0001, 4'b0001, 4'b0000);
        tbl[25] = v(4'b1011, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0001);
        tbl[26] = v(4'b1011, 1, 4'hF, 1, 4'b0000, 4'b0000, 4'b0000);
        tbl[27] = v(4'b1011, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[28] = v(4'b0000, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[29] = v(4'b0100, 0, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[30] = v(4'b0100, 0, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[31] = v(4'b0100, 0, 4'hF, 0, 4'b0000, 4'b0100, 4'b0000);
        tbl[32] = v(4'b0100, 0, 4'hF, 0, 4'b0000, 4'b0100, 4'b0000);
        tbl[33] = v(4'b0100, 1, 4'hF, 0, 4'b0100, 4'b0100, 4'b0000);
        tbl[34] = v(4'b0100, 1, 4'hF, 0, 4'b0000, 4'b0000, 4'b0100);
        tbl[35] = v(4'b0100, 1, 4'hF, 1, 4'b0000, 4'b0000, 4'b0000);
        tbl[36] = v(4'b0100, 1, 4'hF, 1, 4'b0000, 4'b0000, 4'b0000);

        // T1: irq high through reset release is not a request.
        reset = 1'b0;
        irq   = 4'b0001;
        gie   = 1'b1;
        mask  = 4'hF;
        reti  = 1'b0;
        #12;
        chk("reset_ie", ie, 4'b0000);
        chk("reset_pend", pending, 4'b0000);
        chk("reset_isv", in_service, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t1_pend", pending, 4'b0000);
            chk("t1_ie", ie, 4'b0000);
        end
        irq = 4'b0000;
        repeat (4) cyc();

        for (int i = 0; i < 37; i++) begin
            irq  = tbl[i].irq;
            gie  = tbl[i].gie;
            mask = tbl[i].mask;
            reti = tbl[i].reti;
            cyc();
            chk($sformatf("v%0d_ie", i), ie, tbl[i].ie);
            chk($sformatf("v%0d_pend", i), pending, tbl[i].pend);
            chk($sformatf("v%0d_isv", i), in_service, tbl[i].isv);
        end

        // New rise lands in the same cycle the pending bit is cleared.
        gie = 1'b1; mask = 4'hF;
        drv(4'b0000, 0);
        repeat (4) cyc();
        drv(4'b0010, 0); cyc();
        drv(4'b0000, 0); cyc();
        drv(4'b0010, 0); cyc();
        chk("sim_pend0", pending, 4'b0010);
        cyc();
        chk("sim_ie", ie, 4'b0010);
        cyc();
        chk("sim_pend_kept", pending, 4'b0010);
        chk("sim_isv", in_service, 4'b0010);
        cyc();
        drv(4'b0010, 1); cyc();
        chk("sim_reti", in_service, 4'b0000);
        drv(4'b0010, 0);
        wait_ie("sim_refire", 4'b0010, 6);
        cyc();
        chk("sim_isv2", in_service, 4'b0010);
        chk("sim_pend_done", pending, 4'b0000);
        drv(4'b0000, 1); cyc();
        drv(4'b0000, 0);
        repeat (4) cyc();

        // T5: irq[0] arrives while irq[3] is in service.
        drv(4'b1000, 0);
        wait_ie("t5_ie4", 4'b1000, 8);
        cyc();
        chk("t5_isv3", in_service, 4'b1000);
        drv(4'b1001, 0);
        repeat (3) cyc();
        chk("t5_pend0", pending, 4'b0001);
        cyc();
`ifdef INT_NEST_EN
        chk("t5_nest_ie1", ie, 4'b0001);
        cyc();
        chk("t5_nest_isv", in_service, 4'b1001);
        drv(4'b1001, 1); cyc();
        chk("t5_reti_a", in_service, 4'b1000);
        drv(4'b1001, 0); cyc();
        drv(4'b1001, 1); cyc();
        chk("t5_reti_b", in_service, 4'b0000);
        drv(4'b1001, 0); cyc();
`else
        chk("t5_hold_ie", ie, 4'b0000);
        cyc();
        chk("t5_hold_isv", in_service, 4'b1000);
        drv(4'b1001, 1); cyc();
        chk("t5_reti_a", in_service, 4'b0000);
        drv(4'b1001, 0);
        wait_ie("t5_late_ie1", 4'b0001, 6);
        cyc();
        chk("t5_isv0", in_service, 4'b0001);
        drv(4'b1001, 1); cyc();
        chk("t5_reti_b", in_service, 4'b0000);
        drv(4'b1001, 0); cyc();
`endif
        drv(4'b0000, 0);
        repeat (4) cyc();

        // T6: reset asserted during FIRE, then during SERVICE.
        drv(4'b0100, 0);
        wait_ie("t6_fire", 4'b0100, 8);
        reset = 1'b0;
        #1;
        chk("t6_fire_ie", ie, 4'b0000);
        chk("t6_fire_pend", pending, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) cyc();
        chk("t6_noedge", pending, 4'b0000);
        drv(4'b0000, 0);
        repeat (4) cyc();
        drv(4'b0001, 0);
        wait_ie("t6_fire2", 4'b0001, 8);
        cyc();
        chk("t6_svc_isv", in_service, 4'b0001);
        reset = 1'b0;
        #1;
        chk("t6_svc_isv0", in_service, 4'b0000);
        chk("t6_svc_ie", ie, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        drv(4'b0001, 1);
        cyc();
        chk("t6_reti_idle", in_service, 4'b0000);
        drv(4'b0001, 0);
        cyc();
        chk("t6_idle_ie", ie, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
